// File: rtl/dmem_arbiter.sv
// Round-robin two-port arbiter and single-access sequencer in front of the data memory.
// Each access takes one IDLE (grant) cycle and one ACCESS cycle, then sends a registered response pulse.
module dmem_arbiter #(
    parameter int MEM_BYTES = 1024
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        a_req,
    input  logic        a_we,
    input  logic [2:0]  a_funct3,
    input  logic [31:0] a_addr,
    input  logic [31:0] a_wdata,
    output logic        a_gnt,
    output logic        a_rsp_valid,
    output logic        a_rsp_err,
    input  logic        b_req,
    input  logic        b_we,
    input  logic [2:0]  b_funct3,
    input  logic [31:0] b_addr,
    input  logic [31:0] b_wdata,
    output logic        b_gnt,
    output logic        b_rsp_valid,
    output logic        b_rsp_err,
    output logic [31:0] rsp_rdata,
    output logic        busy,
    output logic        mem_read,
    output logic        mem_write,
    output logic [31:0] mem_address,
    output logic [31:0] mem_write_data,
    output logic [2:0]  mem_funct3,
    input  logic [31:0] mem_read_data
);

    typedef enum logic {IDLE, ACCESS} state_t;

    localparam logic [32:0] MEM_LIMIT = 33'(MEM_BYTES);
    localparam logic SRC_A = 1'b0;
    localparam logic SRC_B = 1'b1;

    state_t      state, next_state;
    logic        last_winner;
    logic        cmd_we;
    logic [2:0]  cmd_funct3;
    logic [31:0] cmd_addr;
    logic [31:0] cmd_wdata;
    logic        cmd_src;
    logic        cmd_err;

    logic        grant_a, grant_b, grant_any;
    logic        sel_we;
    logic [2:0]  sel_funct3;
    logic [31:0] sel_addr;
    logic [31:0] sel_wdata;
    logic [2:0]  sel_size;
    logic [32:0] sel_last_byte;
    logic        bad_funct3, misaligned, out_of_range, sel_err;
    logic        mem_active;

    // Arbitration: a lone requester wins; under contention the port that did not win last time wins.
    always_comb begin
        grant_a = 1'b0;
        grant_b = 1'b0;
        if (!rst && state == IDLE) begin
            grant_a = a_req && (!b_req || last_winner == SRC_B);
            grant_b = b_req && (!a_req || last_winner == SRC_A);
        end
        grant_any = grant_a || grant_b;
    end

    always_comb begin
        sel_we     = grant_b ? b_we     : a_we;
        sel_funct3 = grant_b ? b_funct3 : a_funct3;
        sel_addr   = grant_b ? b_addr   : a_addr;
        sel_wdata  = grant_b ? b_wdata  : a_wdata;
    end

    // Legality is judged on the request fields so the ACCESS cycle only has to read one flag.
    always_comb begin
        case (sel_funct3[1:0])
            2'b00:   sel_size = 3'd1;
            2'b01:   sel_size = 3'd2;
            default: sel_size = 3'd4;
        endcase
        if (sel_we)
            bad_funct3 = !(sel_funct3 == 3'b000 || sel_funct3 == 3'b001 || sel_funct3 == 3'b010);
        else
            bad_funct3 = !(sel_funct3 == 3'b000 || sel_funct3 == 3'b001 || sel_funct3 == 3'b010 ||
                           sel_funct3 == 3'b100 || sel_funct3 == 3'b101);
        misaligned    = (sel_funct3[1:0] == 2'b01 && sel_addr[0]) ||
                        (sel_funct3[1:0] == 2'b10 && sel_addr[1:0] != 2'b00);
        sel_last_byte = {1'b0, sel_addr} + 33'(sel_size) - 33'd1;
        out_of_range  = sel_last_byte >= MEM_LIMIT;
        sel_err       = bad_funct3 || misaligned || out_of_range;
    end

    always_ff @(posedge clk) begin
        if (rst)
            state <= IDLE;
        else
            state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (grant_any) next_state = ACCESS;
            ACCESS:  next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_comb begin
        a_gnt          = grant_a;
        b_gnt          = grant_b;
        busy           = (state == ACCESS);
        mem_active     = (state == ACCESS) && !cmd_err;
        mem_read       = mem_active && !rst && !cmd_we;
        mem_write      = mem_active && !rst && cmd_we;
        mem_address    = mem_active ? cmd_addr   : 32'd0;
        mem_write_data = mem_active ? cmd_wdata  : 32'd0;
        mem_funct3     = mem_active ? cmd_funct3 : 3'd0;
    end

    // Command capture at grant and the one-cycle response pulse at the end of ACCESS.
    always_ff @(posedge clk) begin
        if (rst) begin
            last_winner <= SRC_B;
            cmd_we      <= 1'b0;
            cmd_funct3  <= 3'd0;
            cmd_addr    <= 32'd0;
            cmd_wdata   <= 32'd0;
            cmd_src     <= SRC_A;
            cmd_err     <= 1'b0;
            rsp_rdata   <= 32'd0;
            a_rsp_valid <= 1'b0;
            a_rsp_err   <= 1'b0;
            b_rsp_valid <= 1'b0;
            b_rsp_err   <= 1'b0;
        end else begin
            a_rsp_valid <= 1'b0;
            a_rsp_err   <= 1'b0;
            b_rsp_valid <= 1'b0;
            b_rsp_err   <= 1'b0;
            if (state == IDLE && grant_any) begin
                last_winner <= grant_b ? SRC_B : SRC_A;
                cmd_we      <= sel_we;
                cmd_funct3  <= sel_funct3;
                cmd_addr    <= sel_addr;
                cmd_wdata   <= sel_wdata;
                cmd_src     <= grant_b ? SRC_B : SRC_A;
                cmd_err     <= sel_err;
            end
            if (state == ACCESS) begin
                rsp_rdata <= (!cmd_we && !cmd_err) ? mem_read_data : 32'd0;
                if (cmd_src == SRC_A) begin
                    a_rsp_valid <= 1'b1;
                    a_rsp_err   <= cmd_err;
                end else begin
                    b_rsp_valid <= 1'b1;
                    b_rsp_err   <= cmd_err;
                end
            end
        end
    end

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Two-port arbiter and access sequencer in front of the single-port byte-addressed data memory (1 KB, combinational read, write on posedge).
- Port A is the core load/store unit; port B is the debug/program-loader master.
- Grants round-robin, registers the winning command, checks alignment, range and funct3 legality, drives one memory access, and returns a registered response to the winner.

Parameters:
- MEM_BYTES, 1024, memory size in bytes; an access is legal only if every byte it touches is < MEM_BYTES.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- a_req  in  1  port A request; held with fields stable until a_gnt
- a_we  in  1  1 = store, 0 = load
- a_funct3  in  3  RV32 load/store funct3
- a_addr  in  32  byte address
- a_wdata  in  32  store data (low bytes used for SB/SH)
- a_gnt  out  1  request accepted this cycle
- a_rsp_valid  out  1  one-cycle response pulse
- a_rsp_err  out  1  qualifies a_rsp_valid: access rejected
- b_req, b_we, b_funct3, b_addr, b_wdata, b_gnt, b_rsp_valid, b_rsp_err: same as port A
- rsp_rdata  out  32  load data, shared; valid with either rsp_valid
- busy  out  1  state == ACCESS
- mem_read  out  1  to data memory
- mem_write  out  1  to data memory
- mem_address  out  32  to data memory
- mem_write_data  out  32  to data memory
- mem_funct3  out  3  to data memory
- mem_read_data  in  32  from data memory (combinational)

Behaviour:
- Clock `clk`; reset `rst` is synchronous, active-high.
- Reset values: state=IDLE, last_winner=B, cmd regs=0, rsp_rdata=0, all rsp_valid/rsp_err=0. Gnt outputs are 0 while rst is high.
- FSM IDLE:
  - If any req is high, pick a winner and assert its gnt combinationally this cycle.
  - At posedge, latch {we, funct3, addr, wdata, src, err} and go to ACCESS.
  - If no req, stay in IDLE.
- FSM ACCESS:
  - No gnt is asserted.
  - Memory is driven from the latched cmd.
  - At posedge: rsp_rdata <= (load && !err) ? mem_read_data : 0; the winner's rsp_valid <= 1 and rsp_err <= err; go to IDLE.
- rsp_valid and rsp_err are single-cycle pulses. Throughput is 1 access per 2 cycles.
- Latency: gnt in cycle N, memory access in N+1, rsp_valid in N+2. A new gnt may coincide with rsp_valid in N+2.
- Arbitration:
  - Only one req: that port wins.
  - Both req: the port not equal to last_winner wins. last_winner updates on every grant.
  - First contention after reset goes to A.
- Memory drive in ACCESS with err=0:
  - mem_read = !we; mem_write = we.
  - mem_address, mem_funct3, mem_write_data come from the cmd regs.
  - In IDLE, or when err=1, mem_read=mem_write=0 and the address/data/funct3 outputs are 0.
  - mem_read and mem_write are gated to 0 whenever rst is high.
- err is computed at grant from the request fields:
  - Illegal funct3: store not in {000,001,010}; load not in {000,001,010,100,101}.
  - Misaligned: halfword with addr[0]=1; word with addr[1:0]!=0.
  - Out of range: addr + size − 1 ≥ MEM_BYTES, with size 1/2/4 from funct3[1:0]. Computed without 32-bit wrap, so addr=0xFFFFFFFF is out of range.
  - err responses are ordinary pulses with rsp_rdata=0; the memory is untouched.
- Reset mid-operation: rst in ACCESS suppresses the write, returns to IDLE, and drops any pending response (no rsp_valid).
- A requester that keeps req high after gnt is treated as issuing a new request. It is arbitrated in the next IDLE cycle.

Test Plan:
- A-only SW addr=0x10 wdata=0xDEADBEEF, then A LW 0x10 → gnts 2 cycles apart; the second a_rsp_valid has rsp_rdata=0xDEADBEEF and a_rsp_err=0; b_* stays 0.
- Both req continuously right after reset (A LW 0x0, B LW 0x4) → gnt order A,B,A,B. Each rsp_valid goes to the matching port 2 cycles after its gnt. A gnt never occurs in a busy=1 cycle.
- B SH addr=0x21 → b_rsp_err=1, rsp_rdata=0, mem_write stays 0 in ACCESS; a following LW 0x20 returns the old contents.
- A LW addr=0x3FC → OK. A LW addr=0x3FD → err (misaligned). A LBU 0x400 → err (range). A LB funct3=011 → err. A SW addr=0xFFFFFFFC → err.
- A SB 0x8 = 0x80, then A LB 0x8 → 0xFFFFFF80; A LBU 0x8 → 0x00000080.
- Assert rst for 1 cycle during the ACCESS of A SW 0x30 = 0x12345678 → no a_rsp_valid, state IDLE, mem_write=0 in the rst cycle. After reset, the next contention is granted to A.
